// File: rtl/quad_input_conditioner_if.sv
// -----------------------------------------------------------------------------
// quad_input_conditioner_if
// Groups the quadrature pins, control strobes and conditioned outputs of the
// encoder front end into one bundle.
//   a_raw, b_raw   : raw encoder pins (asynchronous to the system clock)
//   bypass         : 1 = skip debounce, clean levels follow the synchroniser
//   err_clr        : synchronous clear of illegal_err and glitch_cnt
//   a_clean/b_clean: debounced channel levels
//   edge_valid     : 1-cycle pulse when exactly one clean channel changed
//   illegal_err    : sticky flag, both clean channels changed on one edge
//   glitch_cnt     : saturating count of rejected pulses
// master = the side driving the pins (encoder/test side),
// slave  = the conditioner itself.
// -----------------------------------------------------------------------------
interface quad_input_conditioner_if;
    logic       a_raw;
    logic       b_raw;
    logic       bypass;
    logic       err_clr;
    logic       a_clean;
    logic       b_clean;
    logic       edge_valid;
    logic       illegal_err;
    logic [3:0] glitch_cnt;

    modport master (
        output a_raw, b_raw, bypass, err_clr,
        input  a_clean, b_clean, edge_valid, illegal_err, glitch_cnt
    );

    modport slave (
        input  a_raw, b_raw, bypass, err_clr,
        output a_clean, b_clean, edge_valid, illegal_err, glitch_cnt
    );
endinterface

// File: rtl/quad_input_conditioner.sv
// -----------------------------------------------------------------------------
// quad_input_conditioner
// Front end for the rotary-encoder decoder. Each quadrature pin is passed
// through a two-flop synchroniser and a stable-count debounce filter; the
// resulting clean A/B levels are Gray-code safe for the decoder. Double
// transitions of the clean levels are flagged, rejected pulses are counted.
// Ports:
//   clk_in   : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : quad_input_conditioner_if.slave (pins, controls, outputs)
// Parameters:
//   DEBOUNCE_W   : width of the per-channel stability counter
//   DEBOUNCE_LEN : consecutive differing cycles needed to accept a level
//                  (1 .. 2**DEBOUNCE_W)
// -----------------------------------------------------------------------------
module quad_input_conditioner #(
    parameter int DEBOUNCE_W   = 4,
    parameter int DEBOUNCE_LEN = 8
) (
    input  logic                     clk_in,
    input  logic                     reset_n,
    quad_input_conditioner_if.slave  bus
);
    // Counter value seen on the DEBOUNCE_LEN-th consecutive differing edge.
    localparam logic [DEBOUNCE_W-1:0] LAST_CNT = DEBOUNCE_W'(DEBOUNCE_LEN - 1);

    // Bit 0 = channel A, bit 1 = channel B.
    logic [1:0] raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] clean_q;
    logic [1:0] clean_d;
    logic [1:0] glitch_ev;
    logic [1:0] changed;
    logic [1:0] ev_count;
    logic       bypass_q;
    logic       bypass_chg;
    logic       edge_valid_q;
    logic       edge_valid_d;
    logic       illegal_q;
    logic       illegal_d;
    logic [3:0] glitch_q;
    logic [3:0] glitch_d;
    logic [4:0] glitch_sum;

    assign raw        = {bus.b_raw, bus.a_raw};
    assign bypass_chg = bus.bypass ^ bypass_q;

    // Per-channel debounce filter.
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic [DEBOUNCE_W-1:0] cnt_q;
        logic [DEBOUNCE_W-1:0] cnt_d;
        logic                  clean_nx;
        logic                  glitch;

        always_comb begin
            cnt_d    = cnt_q;
            clean_nx = clean_q[gi];
            glitch   = 1'b0;
            if (bypass_chg) begin
                // Mode switch restarts the stability count; level untouched.
                cnt_d = '0;
            end else if (bus.bypass) begin
                cnt_d    = '0;
                clean_nx = sync2_q[gi];
            end else if (sync2_q[gi] != clean_q[gi]) begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d    = '0;
                    clean_nx = sync2_q[gi];
                end else begin
                    cnt_d = cnt_q + DEBOUNCE_W'(1);
                end
            end else if (cnt_q != '0) begin
                // Input fell back before the count completed: pulse rejected.
                cnt_d  = '0;
                glitch = 1'b1;
            end
        end

        always_ff @(posedge clk_in or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign clean_d[gi]   = clean_nx;
        assign glitch_ev[gi] = glitch;
    end

    // Change detection looks at the next clean values against current ones,
    // so edge_valid/illegal_err line up with the cycle the new level appears.
    assign changed      = clean_d ^ clean_q;
    assign edge_valid_d = changed[0] ^ changed[1];
    assign illegal_d    = (changed[0] & changed[1]) | (illegal_q & ~bus.err_clr);

    assign ev_count   = {1'b0, glitch_ev[0]} + {1'b0, glitch_ev[1]};
    assign glitch_sum = {1'b0, glitch_q} + {3'b000, ev_count};

    // A clear on an edge with new events keeps those events.
    always_comb begin
        glitch_d = glitch_q;
        if (bus.err_clr) begin
            glitch_d = {2'b00, ev_count};
        end else if (glitch_sum > 5'd15) begin
            glitch_d = 4'hF;
        end else begin
            glitch_d = glitch_sum[3:0];
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            clean_q      <= '0;
            bypass_q     <= 1'b0;
            edge_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            glitch_q     <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            clean_q      <= clean_d;
            bypass_q     <= bus.bypass;
            edge_valid_q <= edge_valid_d;
            illegal_q    <= illegal_d;
            glitch_q     <= glitch_d;
        end
    end

    assign bus.a_clean     = clean_q[0];
    assign bus.b_clean     = clean_q[1];
    assign bus.edge_valid  = edge_valid_q;
    assign bus.illegal_err = illegal_q;
    assign bus.glitch_cnt  = glitch_q;

endmodule

// File: tb/tb_quad_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_quad_input_conditioner
// Directed scenarios plus a randomized phase. A behavioural model tracks, per
// channel, the raw level delayed by the synchroniser and the run length of
// consecutive cycles it disagrees with the accepted level; all DUT outputs are
// compared against it every cycle, with scenario-level checks on top.
// -----------------------------------------------------------------------------
module tb_quad_input_conditioner;
    localparam int W   = 4;
    localparam int LEN = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    quad_input_conditioner_if qif();

    quad_input_conditioner #(
        .DEBOUNCE_W   (W),
        .DEBOUNCE_LEN (LEN)
    ) dut (
        .clk_in  (clk),
        .reset_n (rst_n),
        .bus     (qif)
    );

    int checks   = 0;
    int failures = 0;
    int dut_ev   = 0;

    // Reference model state
    logic [1:0] m_h1;      // raw sampled one edge ago
    logic [1:0] m_h2;      // raw sampled two edges ago (what the filter sees)
    logic [1:0] m_clean;
    int         m_run [2];
    logic       m_byp_prev;
    logic       m_ev;
    logic       m_ill;
    int         m_gl;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_h1 = '0; m_h2 = '0; m_clean = '0;
        m_run[0] = 0; m_run[1] = 0;
        m_byp_prev = 1'b0; m_ev = 1'b0; m_ill = 1'b0; m_gl = 0;
    endtask

    task automatic check_outputs();
        check_val("a_clean",     int'(qif.a_clean),     int'(m_clean[0]));
        check_val("b_clean",     int'(qif.b_clean),     int'(m_clean[1]));
        check_val("edge_valid",  int'(qif.edge_valid),  int'(m_ev));
        check_val("illegal_err", int'(qif.illegal_err), int'(m_ill));
        check_val("glitch_cnt",  int'(qif.glitch_cnt),  m_gl);
    endtask

    // One rising edge: advance the model from the inputs present at the edge,
    // then compare shortly after the edge.
    task automatic tick();
        logic [1:0] raw;
        logic [1:0] nclean;
        logic [1:0] chg;
        logic       byp;
        logic       clr;
        int         ev;
        @(posedge clk);
        raw = {qif.b_raw, qif.a_raw};
        byp = qif.bypass;
        clr = qif.err_clr;
        nclean = m_clean;
        ev = 0;
        for (int c = 0; c < 2; c++) begin
            if (byp != m_byp_prev) begin
                m_run[c] = 0;
            end else if (byp) begin
                nclean[c] = m_h2[c];
                m_run[c] = 0;
            end else if (m_h2[c] != m_clean[c]) begin
                m_run[c] = m_run[c] + 1;
                if (m_run[c] == LEN) begin
                    nclean[c] = m_h2[c];
                    m_run[c] = 0;
                end
            end else if (m_run[c] != 0) begin
                m_run[c] = 0;
                ev = ev + 1;
            end
        end
        chg = nclean ^ m_clean;
        m_ev  = (chg == 2'b01) || (chg == 2'b10);
        m_ill = (chg == 2'b11) || (m_ill && !clr);
        if (clr) m_gl = ev;
        else     m_gl = (m_gl + ev > 15) ? 15 : m_gl + ev;
        m_clean = nclean;
        m_byp_prev = byp;
        m_h2 = m_h1;
        m_h1 = raw;
        #1;
        if (qif.edge_valid) dut_ev++;
        check_outputs();
    endtask

    task automatic cycle(input logic a, input logic b, input logic byp, input logic clr);
        @(negedge clk);
        qif.a_raw = a; qif.b_raw = b; qif.bypass = byp; qif.err_clr = clr;
        tick();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_a"},   int'(qif.a_clean),     0);
        check_val({tag, "_b"},   int'(qif.b_clean),     0);
        check_val({tag, "_ev"},  int'(qif.edge_valid),  0);
        check_val({tag, "_ill"}, int'(qif.illegal_err), 0);
        check_val({tag, "_gl"},  int'(qif.glitch_cnt),  0);
    endtask

    initial begin
        int   first_rise;
        int   ev0;
        logic seen;
        int   len;
        logic ra, rb, rbyp;
        logic [1:0] steps [4];

        rst_n = 1'b0;
        qif.a_raw = 1'b0; qif.b_raw = 1'b0; qif.bypass = 1'b0; qif.err_clr = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        release_reset();
        repeat (3) cycle(0, 0, 0, 0);

        // 1: A rises and is held; accepted LEN+1 edges after capture
        ev0 = dut_ev;
        first_rise = -1;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 0, 0);
            if (qif.a_clean && first_rise < 0) first_rise = i;
        end
        check_val("s1_latency", first_rise, LEN + 1);
        check_val("s1_pulses", dut_ev - ev0, 1);
        check_val("s1_glitch", int'(qif.glitch_cnt), 0);
        $display("scenario 1: a_clean rose %0d edges after capture", first_rise);

        // 2: short A pulse is rejected
        repeat (20) cycle(0, 0, 0, 0);
        ev0 = dut_ev;
        seen = 1'b0;
        repeat (5) begin cycle(1, 0, 0, 0); seen |= qif.a_clean; end
        repeat (15) begin cycle(0, 0, 0, 0); seen |= qif.a_clean; end
        check_val("s2_a_stuck", int'(seen), 0);
        check_val("s2_pulses", dut_ev - ev0, 0);
        check_val("s2_glitch", int'(qif.glitch_cnt), 1);
        $display("scenario 2: 5-cycle pulse, glitch_cnt=%0d", qif.glitch_cnt);

        // 3: clockwise Gray sequence, entries are {B,A}
        steps[0] = 2'b01; steps[1] = 2'b11; steps[2] = 2'b10; steps[3] = 2'b00;
        ev0 = dut_ev;
        for (int s = 0; s < 4; s++) begin
            repeat (12) cycle(steps[s][0], steps[s][1], 0, 0);
            check_val("s3_level", int'({qif.b_clean, qif.a_clean}), int'(steps[s]));
        end
        check_val("s3_pulses", dut_ev - ev0, 4);
        check_val("s3_illegal", int'(qif.illegal_err), 0);
        $display("scenario 3: gray sequence, %0d edge pulses", dut_ev - ev0);

        // 4: simultaneous change on both channels
        ev0 = dut_ev;
        repeat (12) cycle(1, 1, 0, 0);
        check_val("s4_illegal_set", int'(qif.illegal_err), 1);
        check_val("s4_no_pulse", dut_ev - ev0, 0);
        cycle(1, 1, 0, 1);
        check_val("s4_cleared", int'(qif.illegal_err), 0);
        for (int i = 0; i <= LEN + 1; i++) cycle(0, 0, 0, (i == LEN + 1));
        check_val("s4_set_wins", int'(qif.illegal_err), 1);
        repeat (3) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        $display("scenario 4: double change flagged, clear/set collision held");

        // 5: burst of short glitches saturates the counter
        for (int p = 0; p < 20; p++) begin
            repeat ($urandom_range(1, LEN - 1)) cycle(1, 0, 0, 0);
            repeat ($urandom_range(4, 10)) cycle(0, 0, 0, 0);
        end
        check_val("s5_saturated", int'(qif.glitch_cnt), 15);
        cycle(0, 0, 0, 1);
        check_val("s5_cleared", int'(qif.glitch_cnt), 0);
        $display("scenario 5: 20 glitches, counter saturated then cleared");

        // 6: bypass follows the synchroniser; async reset mid-count
        repeat (4) cycle(0, 0, 1, 0);
        cycle(1, 0, 1, 0);
        cycle(1, 0, 1, 0);
        check_val("s6_a_not_yet", int'(qif.a_clean), 0);
        cycle(1, 0, 1, 0);
        check_val("s6_a_follow", int'(qif.a_clean), 1);
        cycle(1, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 check_all_zero("s6_async");
        m_reset();
        @(negedge clk);
        release_reset();
        repeat (3) cycle(0, 0, 0, 0);
        $display("scenario 6: bypass latency and async reset checked");

        // Randomized phase
        rbyp = 1'b0;
        for (int blk = 0; blk < 120; blk++) begin
            len = $urandom_range(1, 20);
            ra = 1'($urandom_range(0, 1));
            rb = ($urandom_range(0, 3) == 0) ? ra : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) rbyp = ~rbyp;
            for (int i = 0; i < len; i++) cycle(ra, rb, rbyp, ($urandom_range(0, 19) == 0));
            if (blk == 60) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero("rand_async");
                m_reset();
                @(negedge clk);
                release_reset();
            end
        end
        $display("random phase: 120 blocks, %0d edge pulses total", dut_ev);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
